// File: rtl/breath_led_pkg.sv
// Shared definitions for the breathing LED array.
// Holds the 2-bit mode encoding that is used on the mode port and in the
// internal mode latch.
package breath_led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_BREATHE = 2'd1,
      MODE_SOLID   = 2'd2,
      MODE_CHASE   = 2'd3
   } mode_t;

endpackage

// File: rtl/breath_tri.sv
// Combinational phase-to-duty triangle mapper.
// Ports:
//   phase : breathing phase, 0..2*MAX-1
//   duty  : PWM duty, rises 0..MAX over the first half of the phase range
//           and falls back toward 0 over the second half
module breath_tri #(
   parameter int PWM_BITS = 8
) (
   input  logic [PWM_BITS:0]   phase,
   output logic [PWM_BITS-1:0] duty
);

   localparam int MAX       = (1 << PWM_BITS) - 1;
   localparam int TWO_MAX_I = 2 * MAX;
   localparam logic [PWM_BITS:0] MAX_V     = MAX[PWM_BITS:0];
   localparam logic [PWM_BITS:0] TWO_MAX_V = TWO_MAX_I[PWM_BITS:0];

   logic [PWM_BITS:0] refl;

   always_comb begin
      refl = TWO_MAX_V - phase;
      if (phase <= MAX_V) duty = phase[PWM_BITS-1:0];
      else                duty = refl[PWM_BITS-1:0];
   end

endmodule

// File: rtl/breath_led_array.sv
// Breathing / chasing LED driver for CHANNELS outputs.
// A shared PWM counter, step counter and phase accumulator feed one
// triangle mapper per channel; led is registered from the PWM compare.
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   enable     : 1 = run, 0 = freeze counters and force LEDs off
//   mode       : 0 OFF, 1 BREATHE, 2 SOLID, 3 CHASE (latched at period end)
//   led        : registered LED drive, 1 = on
//   cycle_done : one-clock pulse when the phase accumulator wraps
module breath_led_array
   import breath_led_pkg::*;
#(
   parameter int CHANNELS     = 4,
   parameter int PWM_BITS     = 8,
   parameter int STEP_PERIODS = 196,
   parameter int PHASE_OFS    = 128
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [1:0]          mode,
   output logic [CHANNELS-1:0] led,
   output logic                cycle_done
);

   localparam int MAX       = (1 << PWM_BITS) - 1;
   localparam int PH_W      = PWM_BITS + 1;
   localparam int CW        = PWM_BITS + 6;
   localparam int SC_W      = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
   localparam int MAX_M1    = MAX - 1;
   localparam int SC_LAST_I = STEP_PERIODS - 1;
   localparam int PH_LAST_I = 2 * MAX - 1;
   localparam int TWO_MAX_I = 2 * MAX;

   localparam logic [PWM_BITS-1:0] PWM_LAST  = MAX_M1[PWM_BITS-1:0];
   localparam logic [SC_W-1:0]     SC_LAST   = SC_LAST_I[SC_W-1:0];
   localparam logic [PH_W-1:0]     PH_LAST   = PH_LAST_I[PH_W-1:0];
   localparam logic [CW-1:0]       TWO_MAX_W = TWO_MAX_I[CW-1:0];

   if (CHANNELS < 1 || CHANNELS > 32 || PWM_BITS < 2 || PWM_BITS > 16 ||
       STEP_PERIODS < 1 || PHASE_OFS < 0 || PHASE_OFS >= 2 * MAX) begin : g_param_err
      $error("breath_led_array: illegal parameter combination");
   end

   logic [PWM_BITS-1:0] pwm_cnt;
   logic [SC_W-1:0]     sc;
   logic [PH_W-1:0]     ph;
   mode_t               mode_q;
   logic [CHANNELS-1:0] c;

   logic period_end;
   logic step_end;
   logic ph_wrap;

   assign period_end = (pwm_cnt == PWM_LAST);
   assign step_end   = period_end && (sc == SC_LAST);
   assign ph_wrap    = step_end && (ph == PH_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt    <= '0;
         sc         <= '0;
         ph         <= '0;
         mode_q     <= MODE_OFF;
         led        <= '0;
         cycle_done <= 1'b0;
      end else if (!enable) begin
         led        <= '0;
         cycle_done <= 1'b0;
      end else begin
         led        <= c;
         cycle_done <= ph_wrap;
         if (period_end) begin
            pwm_cnt <= '0;
            // Mode only changes on a period boundary so a running pulse is never cut short.
            mode_q  <= mode_t'(mode);
            if (step_end) begin
               sc <= '0;
               ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
            end else begin
               sc <= sc + 1'b1;
            end
         end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
         end
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      // Per-channel offset folded into 0..2*MAX-1 at elaboration, so one
      // conditional subtract is enough to wrap ph + offset at run time.
      localparam int OFS_I = (k * PHASE_OFS) % (2 * MAX);
      localparam logic [CW-1:0] OFS_W = OFS_I[CW-1:0];

      logic [CW-1:0]       sum_k;
      logic [PH_W-1:0]     phase_k;
      logic [PWM_BITS-1:0] duty_k;

      assign sum_k   = {{(CW-PH_W){1'b0}}, ph} + OFS_W;
      assign phase_k = (mode_q == MODE_CHASE)
                       ? PH_W'((sum_k >= TWO_MAX_W) ? (sum_k - TWO_MAX_W) : sum_k)
                       : ph;

      breath_tri #(.PWM_BITS(PWM_BITS)) u_tri (
         .phase (phase_k),
         .duty  (duty_k)
      );

      assign c[k] = (mode_q == MODE_SOLID) ||
                    (((mode_q == MODE_BREATHE) || (mode_q == MODE_CHASE)) && (pwm_cnt < duty_k));
   end

endmodule

// File: tb/tb_breath_led_array.sv
// Self-checking bench for breath_led_array (PWM_BITS=3, STEP_PERIODS=1,
// CHANNELS=4, PHASE_OFS=3). A time-indexed reference model predicts led and
// cycle_done on every clock; directed steps add on-count and timing checks.
module tb_breath_led_array;
   import breath_led_pkg::*;

   localparam int PB   = 3;
   localparam int MAXV = 7;
   localparam int STEP = 1;
   localparam int CH   = 4;
   localparam int OFS  = 3;
   localparam int CYC  = 2 * MAXV * STEP * MAXV;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic [1:0]    mode = MODE_OFF;
   logic [CH-1:0] led;
   logic          cycle_done;

   int n_tests = 0;
   int n_fail  = 0;

   int            m_t = 0;
   logic [1:0]    m_modeq = MODE_OFF;
   logic [CH-1:0] exp_led = '0;
   logic          exp_cd = 1'b0;

   breath_led_array #(
      .CHANNELS(CH), .PWM_BITS(PB), .STEP_PERIODS(STEP), .PHASE_OFS(OFS)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode),
      .led(led), .cycle_done(cycle_done)
   );

   always #5 clk = ~clk;

   // LED pattern for t enabled clocks after reset under latched mode mq.
   function automatic logic [CH-1:0] ref_led(int t, logic [1:0] mq);
      logic [CH-1:0] r;
      int pwm, ph, p, duty;
      pwm = t % MAXV;
      ph  = (t / (MAXV * STEP)) % (2 * MAXV);
      for (int k = 0; k < CH; k++) begin
         p    = (mq == MODE_CHASE) ? (ph + k * OFS) % (2 * MAXV) : ph;
         duty = (p <= MAXV) ? p : 2 * MAXV - p;
         if (mq == MODE_SOLID)    r[k] = 1'b1;
         else if (mq == MODE_OFF) r[k] = 1'b0;
         else                     r[k] = (pwm < duty);
      end
      return r;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick(logic r, logic en, logic [1:0] m);
      rst = r; enable = en; mode = m;
      @(posedge clk);
      if (r) begin
         exp_led = '0; exp_cd = 1'b0; m_t = 0; m_modeq = MODE_OFF;
      end else if (!en) begin
         exp_led = '0; exp_cd = 1'b0;
      end else begin
         exp_led = ref_led(m_t, m_modeq);
         if (m_t % MAXV == MAXV - 1) m_modeq = m;
         m_t++;
         exp_cd = (m_t % CYC == 0);
      end
      #1;
      check("led", led, exp_led);
      check("cycle_done", cycle_done, exp_cd);
   endtask

   int c3[CH], c7[CH], c0[CH], cc[CH];
   int exp_chase[CH] = '{0, 3, 6, 5};
   int cd_n, cd1, cd2, cd_at;
   logic [1:0] cur_mode;

   initial begin
      // Reset held with SOLID requested, then first period stays dark.
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, MODE_SOLID);
      for (int i = 1; i <= 8; i++) begin
         tick(1'b0, 1'b1, MODE_SOLID);
         if (i == 7) check("solid_first_period", led, 4'h0);
         if (i == 8) check("solid_on", led, 4'hF);
      end

      // Breathe: on-counts at chosen phases and cycle_done spacing.
      tick(1'b1, 1'b1, MODE_BREATHE);
      tick(1'b1, 1'b1, MODE_BREATHE);
      for (int k = 0; k < CH; k++) begin c3[k] = 0; c7[k] = 0; c0[k] = 0; end
      cd_n = 0; cd1 = -1; cd2 = -1;
      for (int i = 1; i <= 2 * CYC; i++) begin
         tick(1'b0, 1'b1, MODE_BREATHE);
         if (cycle_done) begin
            cd_n++;
            if (cd_n == 1) cd1 = i; else cd2 = i;
         end
         for (int k = 0; k < CH; k++) begin
            if (i >= 22 && i <= 28)   c3[k] += int'(led[k]);
            if (i >= 50 && i <= 56)   c7[k] += int'(led[k]);
            if (i >= 99 && i <= 105)  c0[k] += int'(led[k]);
         end
      end
      for (int k = 0; k < CH; k++) begin
         check("breathe_ph3", c3[k], 3);
         check("breathe_ph7", c7[k], 7);
         check("breathe_ph0_wrap", c0[k], 0);
      end
      check("cycle_done_first", cd1, 98);
      check("cycle_done_second", cd2, 196);
      check("cycle_done_count", cd_n, 2);

      // Chase at ph=0 (second pass through phase 0).
      tick(1'b1, 1'b1, MODE_CHASE);
      for (int k = 0; k < CH; k++) cc[k] = 0;
      for (int i = 1; i <= 105; i++) begin
         tick(1'b0, 1'b1, MODE_CHASE);
         if (i >= 99)
            for (int k = 0; k < CH; k++) cc[k] += int'(led[k]);
      end
      for (int k = 0; k < CH; k++) check("chase_ph0", cc[k], exp_chase[k]);

      // Freeze for 20 clocks mid-cycle.
      tick(1'b1, 1'b1, MODE_BREATHE);
      for (int i = 1; i <= 30; i++) tick(1'b0, 1'b1, MODE_BREATHE);
      for (int i = 31; i <= 50; i++) begin
         tick(1'b0, 1'b0, MODE_BREATHE);
         check("freeze_led", led, 4'h0);
      end
      cd_at = -1;
      for (int i = 51; i <= 200; i++) begin
         tick(1'b0, 1'b1, MODE_BREATHE);
         if (cycle_done && cd_at < 0) cd_at = i;
      end
      check("freeze_cycle_done_delay", cd_at, 118);

      // Mode change BREATHE -> OFF at pwm_cnt=2 during the all-on period.
      tick(1'b1, 1'b1, MODE_BREATHE);
      for (int i = 1; i <= 51; i++) tick(1'b0, 1'b1, MODE_BREATHE);
      for (int i = 52; i <= 60; i++) begin
         tick(1'b0, 1'b1, MODE_OFF);
         check("mode_change", led, (i <= 56) ? 32'hF : 32'h0);
      end

      // Randomised run: mode changes, enable drops and occasional resets.
      cur_mode = MODE_BREATHE;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 15) == 0) cur_mode = 2'($urandom_range(0, 3));
         tick(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) != 0), cur_mode);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/breath_led_array.md
BREATH_LED_ARRAY -- requirements
Module: breath_led_array

Interface
REQ-001 Parameter CHANNELS, default 4, sets the number of LED outputs; the legal range SHALL be 1..32.
REQ-002 Parameter PWM_BITS, default 8, sets duty resolution, with MAX = 2^PWM_BITS-1; the legal range SHALL be 2..16.
REQ-003 Parameter STEP_PERIODS, default 196, sets the number of PWM periods per breathing phase step, and SHALL be >= 1.
REQ-004 Parameter PHASE_OFS, default 128, sets the per-channel phase offset in chase mode, and SHALL be < 2*MAX.
REQ-005 The block SHALL reject illegal parameter values with an elaboration-time error.
REQ-006 Port clk SHALL be an input, 1 bit wide: the single system clock; all logic is on its rising edge.
REQ-007 Port rst SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-008 Port enable SHALL be an input, 1 bit wide: 1 = run; 0 = freeze all counters and force LEDs off.
REQ-009 Port mode SHALL be an input, 2 bits wide, encoded as 0 OFF, 1 BREATHE, 2 SOLID, 3 CHASE.
REQ-010 Port led SHALL be an output, CHANNELS bits wide: registered LED drive, 1 = on.
REQ-011 Port cycle_done SHALL be an output, 1 bit wide: a one-clock pulse at each full breathing-cycle wrap.

Function
REQ-012 pwm_cnt SHALL count 0..MAX-1 and wrap, giving a PWM period of MAX clocks; the last clock of a period is the one where pwm_cnt = MAX-1.
REQ-013 Step counter sc SHALL count 0..STEP_PERIODS-1 and advance on the last clock of each period.
REQ-014 The phase accumulator ph SHALL count 0..2*MAX-1 and advance by 1 on the last clock of a period when sc = STEP_PERIODS-1, wrapping from 2*MAX-1 to 0.
REQ-015 Phase-to-duty mapping SHALL be: duty = p for p <= MAX; otherwise duty = 2*MAX-p. This is a triangle wave with values in 0..MAX.
REQ-016 Channel phase in BREATHE mode SHALL be ph for every channel.
REQ-017 Channel phase in CHASE mode SHALL be (ph + k*PHASE_OFS) mod 2*MAX for channel k.
REQ-018 The per-channel computation SHALL use at least PWM_BITS+6 bits so that it does not overflow.
REQ-019 The comparison value c[k] SHALL be (pwm_cnt < duty_k) in BREATHE and CHASE modes, 0 in OFF mode, and 1 in SOLID mode.
REQ-020 duty 0 SHALL give an LED that is never on, and duty MAX SHALL give an LED that is always on.
REQ-021 led[k] SHALL be registered from c[k], with a latency of one clock from pwm_cnt, ph and mode_q to led.
REQ-022 The mode input SHALL be sampled into mode_q only on the last clock of a period, so that a new mode takes effect at the next period start and a mid-period change never truncates a PWM pulse.
REQ-023 The counters pwm_cnt, sc and ph SHALL advance in every mode, including OFF and SOLID, so that phase stays continuous across mode switches.
REQ-024 When enable = 0, pwm_cnt, sc, ph and mode_q SHALL hold their values, led SHALL be 0 on the next clock, and cycle_done SHALL be 0.
REQ-025 When enable rises, counting SHALL resume from the held state.
REQ-026 cycle_done SHALL be registered and high for exactly the one clock in which ph shows 0 after a wrap.
REQ-027 With enable held at 1, cycle_done SHALL repeat every 2*MAX*STEP_PERIODS*MAX clocks.
REQ-028 A simultaneous mode change and phase wrap SHALL both be applied on that same boundary.

Reset
REQ-029 While rst = 1, pwm_cnt, sc and ph SHALL be 0, mode_q SHALL be OFF, led SHALL be all 0, and cycle_done SHALL be 0.
REQ-030 An assertion of rst mid-operation SHALL take effect on the next clock edge, with no partial pulse completed.
REQ-031 The first period after reset release SHALL drive LEDs off regardless of mode, because mode_q is OFF until the first boundary.

Structure
REQ-032 Package breath_led_pkg SHALL hold the mode encodings (MODE_OFF, MODE_BREATHE, MODE_SOLID, MODE_CHASE) and the 2-bit mode typedef.
REQ-033 Sub-module breath_tri SHALL be a combinational phase-to-duty triangle mapper parametrised by PWM_BITS, instantiated once per channel via generate.
REQ-034 The top level SHALL contain the shared counters, the mode latch and the output registers.

Verification (PWM_BITS=3, MAX=7, STEP_PERIODS=1, CHANNELS=4, PHASE_OFS=3; 2*MAX*STEP_PERIODS*MAX = 98)
REQ-035 Reset: hold rst=1 for 5 clocks with mode=SOLID -> led=0000 and cycle_done=0 throughout; led stays 0000 for the first 7 clocks after release, then becomes 1111.
REQ-036 Breathe: mode=BREATHE, enable=1 -> in the period where ph=3 each led is high for exactly 3 of 7 clocks; at ph=7 each led is high 7/7; at ph=0 and after the wrap each led is high 0/7.
REQ-037 Cycle: enable held at 1 from reset release -> cycle_done pulses exactly 1 clock wide at clock 98 after release and again at clock 196.
REQ-038 Chase: mode=CHASE, ph=0 -> per-period on-counts for led[0..3] are 0, 3, 6, 5.
REQ-039 Freeze: drop enable for 20 clocks mid-cycle -> led=0 during the gap, and the next cycle_done is delayed by exactly 20 clocks.
REQ-040 Mode change: switch BREATHE to OFF at pwm_cnt=2 -> the current period completes unchanged and led=0 from the next period start (plus one clock of latency).
